morse_sequencer: RTL and testbench

Message-level controller for the single-letter Morse transmitter. It buffers a queue of letter indices and drives the transmitter's `xmit`/`letter` inputs one letter at a time. It decides when each letter has finished by watching the transmitter's `led` output, then inserts word spaces on request. It shares the transmitter's clock (one clock = one Morse time unit) and sits between user input logic and the transmitter.

---
 rtl/morse_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_morse_sequencer.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// morse_sequencer
// Message-level controller for the single-letter Morse transmitter. Queues
// letter indices and word spaces, feeds them to the transmitter one at a
// time, and watches the transmitter's led to tell when a letter has ended.
//
// Ports
//   clk          transmitter clock, one Morse time unit per cycle
//   reset        asynchronous active-low reset
//   push         enqueue push_letter (0..7 = A..H, 4'hF = word space)
//   push_letter  entry to enqueue
//   abort        flush the queue and return to IDLE
//   led          transmitter led output, monitored
//   xmit         one-cycle transmit strobe
//   letter       letter index to the transmitter, held between strobes
//   full, empty  FIFO status
//   count        FIFO occupancy
//   busy         sequencer not in IDLE
//   done         one-cycle pulse when a letter or space completes
//   err          one-cycle pulse on timeout, invalid entry or dropped push
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | pop the next entry when the queue is not empty
// XMIT       | issue the strobe, arm the led-rise timeout
// WAIT_HIGH  | wait for led to rise; timeout raises err
// WAIT_QUIET | wait for QUIET consecutive low led cycles
// SPACE      | hold off WORD_GAP cycles for a word space
module morse_sequencer #(
   parameter int DEPTH    = 8,
   parameter int QUIET    = 3,
   parameter int WORD_GAP = 7,
   parameter int TIMEOUT  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [3:0]               push_letter,
   input  logic                     abort,
   input  logic                     led,
   output logic                     xmit,
   output logic [3:0]               letter,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_MAX = (QUIET > WORD_GAP)
                            ? ((QUIET > TIMEOUT) ? QUIET : TIMEOUT)
                            : ((WORD_GAP > TIMEOUT) ? WORD_GAP : TIMEOUT);
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // cnt is a down-counter: each wait loads its limit minus one and the
   // terminal count of zero marks the final cycle of the wait.
   localparam logic [CW-1:0] QUIET_LD   = CW'(QUIET - 1);
   localparam logic [CW-1:0] GAP_LD     = CW'(WORD_GAP - 1);
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_XMIT,
      S_WAIT_HIGH,
      S_WAIT_QUIET,
      S_SPACE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      letter_q, letter_d;
   logic            xmit_q, xmit_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [3:0]      mem_q [DEPTH];

   logic            push_ok;
   logic            pop;
   logic [3:0]      head;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full && !abort;

   assign xmit    = xmit_q;
   assign letter  = letter_q;
   assign done    = done_q;
   assign err     = err_q;
   assign count   = count_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      letter_d = letter_q;
      xmit_d   = 1'b0;
      done_d   = 1'b0;
      // A push into a full queue is dropped even if IDLE pops this cycle.
      err_d    = push && full && !abort;
      pop      = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  pop = 1'b1;
                  if (head == 4'hF) begin
                     cnt_d   = GAP_LD;
                     state_d = S_SPACE;
                  end else if (!head[3]) begin
                     letter_d = head;
                     state_d  = S_XMIT;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_XMIT: begin
               xmit_d  = 1'b1;
               cnt_d   = TIMEOUT_LD;
               state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               if (led) begin
                  cnt_d   = QUIET_LD;
                  state_d = S_WAIT_QUIET;
               end else if (cnt_q == '0) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_WAIT_QUIET: begin
               if (led) begin
                  cnt_d = QUIET_LD;
               end else if (cnt_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_SPACE: begin
               if (cnt_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_letter;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         letter_q <= '0;
         xmit_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         letter_q <= letter_d;
         xmit_q   <= xmit_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_morse_sequencer.sv
module tb_morse_sequencer;

   localparam int DEPTH    = 8;
   localparam int QUIET    = 3;
   localparam int WORD_GAP = 7;
   localparam int TIMEOUT  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       push = 1'b0;
   logic [3:0] push_letter = 4'h0;
   logic       abort = 1'b0;
   logic       led_man = 1'b0;
   logic       tx_mode = 1'b0;
   logic       led;
   logic       xmit;
   logic [3:0] letter;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] exp_q [$];

   // behavioral transmitter: on a sampled strobe it plays the letter's
   // dot/dash pattern on led, LSB first, starting the next cycle
   logic [15:0] tx_bits = '0;
   int          tx_len = 0;

   always #5 clk = ~clk;

   assign led = tx_mode ? ((tx_len > 0) && tx_bits[0]) : led_man;

   function automatic logic [15:0] morse_bits(input logic [3:0] l);
      logic [15:0] b;
      int          pos;
      int          n;
      logic [3:0]  dash;
      b = '0;
      pos = 0;
      case (l)
         4'd0: begin n = 2; dash = 4'b0010; end
         4'd1: begin n = 4; dash = 4'b0001; end
         4'd2: begin n = 4; dash = 4'b0101; end
         4'd3: begin n = 3; dash = 4'b0001; end
         4'd4: begin n = 1; dash = 4'b0000; end
         4'd5: begin n = 4; dash = 4'b0100; end
         4'd6: begin n = 3; dash = 4'b0011; end
         4'd7: begin n = 4; dash = 4'b0000; end
         default: begin n = 0; dash = 4'b0000; end
      endcase
      for (int i = 0; i < n; i++) begin
         if (i > 0) pos++;
         if (dash[i]) begin
            b[pos] = 1'b1; b[pos+1] = 1'b1; b[pos+2] = 1'b1;
            pos += 3;
         end else begin
            b[pos] = 1'b1;
            pos++;
         end
      end
      return b;
   endfunction

   function automatic int morse_len(input logic [15:0] b);
      int len;
      len = 0;
      for (int i = 0; i < 16; i++) if (b[i]) len = i + 1;
      return len;
   endfunction

   always @(posedge clk) begin
      if (xmit && tx_mode) begin
         tx_bits <= morse_bits(letter);
         tx_len  <= morse_len(morse_bits(letter));
      end else if (tx_len > 0) begin
         tx_bits <= tx_bits >> 1;
         tx_len  <= tx_len - 1;
      end
   end

   morse_sequencer #(
      .DEPTH(DEPTH), .QUIET(QUIET), .WORD_GAP(WORD_GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .push(push), .push_letter(push_letter),
      .abort(abort), .led(led), .xmit(xmit), .letter(letter), .full(full),
      .empty(empty), .count(count), .busy(busy), .done(done), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({xmit, letter, count, empty, full, busy, done, err} !== {1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_values: got xmit=%0b letter=%0d count=%0d empty=%0b full=%0b busy=%0b done=%0b err=%0b, want 0 0 0 1 0 0 0 0",
                  xmit, letter, count, empty, full, busy, done, err);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({xmit, empty, busy} !== 3'b010) begin
         n_bad++;
         $display("FAIL reset_release: got xmit=%0b empty=%0b busy=%0b, want 0 1 0", xmit, empty, busy);
      end
   endtask

   task automatic test_single();
      int t_x = -1;
      int t_hi = -1;
      int t_done = -1;
      logic [3:0] e;
      tx_mode = 1'b1;
      push = 1'b1;
      push_letter = 4'h4;
      exp_q.push_back(4'h4);
      tick();
      push = 1'b0;
      n_cmp++;
      if (count !== 4'd1 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL single_count: got count=%0d empty=%0b, want 1 0", count, empty);
      end
      for (int i = 1; i <= 30 && t_done < 0; i++) begin
         tick();
         if (xmit) begin
            if (t_x < 0) t_x = i;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL single_extra_xmit: got strobe letter=%0d, want none", letter);
            end else begin
               e = exp_q.pop_front();
               if (letter !== e) begin
                  n_bad++;
                  $display("FAIL single_letter: got %0d want %0d", letter, e);
               end
            end
         end
         if (led) t_hi = i;
         if (done) t_done = i;
      end
      n_cmp++;
      if (t_x != 2) begin
         n_bad++;
         $display("FAIL single_latency: got xmit at cycle %0d, want 2", t_x);
      end
      n_cmp++;
      if (t_done < 0 || t_done != t_hi + 1 + QUIET) begin
         n_bad++;
         $display("FAIL single_done: got done at cycle %0d, want %0d", t_done, t_hi + 1 + QUIET);
      end
      n_cmp++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL single_idle: got busy=%0b empty=%0b, want 0 1", busy, empty);
      end
   endtask

   task automatic test_sequence();
      logic [3:0] seq [3] = '{4'h0, 4'hF, 4'h3};
      int nx = 0;
      int nd = 0;
      int ne = 0;
      int t_d1 = -1;
      int t_x2 = -1;
      logic [3:0] e;
      tx_mode = 1'b1;
      for (int i = 0; i < 160 && nd < 3; i++) begin
         if (i < 3) begin
            push = 1'b1;
            push_letter = seq[i];
            if (seq[i] != 4'hF) exp_q.push_back(seq[i]);
         end else begin
            push = 1'b0;
         end
         tick();
         if (xmit) begin
            nx++;
            if (nx == 2) t_x2 = i;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL seq_extra_xmit: got strobe letter=%0d, want none", letter);
            end else begin
               e = exp_q.pop_front();
               if (letter !== e) begin
                  n_bad++;
                  $display("FAIL seq_letter: got %0d want %0d", letter, e);
               end
            end
         end
         if (done) begin
            nd++;
            if (nd == 1) t_d1 = i;
         end
         if (err) ne++;
      end
      push = 1'b0;
      n_cmp++;
      if (nx != 2) begin
         n_bad++;
         $display("FAIL seq_xmit_count: got %0d want 2", nx);
      end
      n_cmp++;
      if (nd != 3) begin
         n_bad++;
         $display("FAIL seq_done_count: got %0d want 3", nd);
      end
      n_cmp++;
      if (t_x2 - t_d1 != WORD_GAP + 3) begin
         n_bad++;
         $display("FAIL seq_space_gap: got %0d cycles want %0d", t_x2 - t_d1, WORD_GAP + 3);
      end
      n_cmp++;
      if (ne != 0) begin
         n_bad++;
         $display("FAIL seq_err: got %0d err pulses want 0", ne);
      end
   endtask

   task automatic test_timeout_invalid();
      int t_x = -1;
      int t_err = -1;
      int nd = 0;
      int nx = 0;
      int ne = 0;
      logic [3:0] e;
      tx_mode = 1'b0;
      led_man = 1'b0;
      for (int i = 0; i < 20 && t_err < 0; i++) begin
         push = (i == 0);
         push_letter = 4'h1;
         if (i == 0) exp_q.push_back(4'h1);
         tick();
         if (xmit) begin
            if (t_x < 0) t_x = i;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL tmo_extra_xmit: got strobe letter=%0d, want none", letter);
            end else begin
               e = exp_q.pop_front();
               if (letter !== e) begin
                  n_bad++;
                  $display("FAIL tmo_letter: got %0d want %0d", letter, e);
               end
            end
         end
         if (done) nd++;
         if (err) t_err = i;
      end
      push = 1'b0;
      n_cmp++;
      if (t_x < 0 || t_err - t_x != TIMEOUT) begin
         n_bad++;
         $display("FAIL tmo_err_time: got err %0d cycles after xmit, want %0d", t_err - t_x, TIMEOUT);
      end
      n_cmp++;
      if (busy !== 1'b0 || nd != 0) begin
         n_bad++;
         $display("FAIL tmo_idle: got busy=%0b done_pulses=%0d, want 0 0", busy, nd);
      end
      t_err = -1;
      for (int i = 0; i < 8; i++) begin
         push = (i == 0);
         push_letter = 4'h9;
         tick();
         if (err) begin
            ne++;
            if (t_err < 0) t_err = i;
         end
         if (xmit) nx++;
         if (i == 1) begin
            n_cmp++;
            if (count !== 4'd0) begin
               n_bad++;
               $display("FAIL inv_count: got %0d want 0", count);
            end
         end
      end
      push = 1'b0;
      n_cmp++;
      if (ne != 1 || t_err != 1) begin
         n_bad++;
         $display("FAIL inv_err: got %0d pulses first at cycle %0d, want 1 at cycle 1", ne, t_err);
      end
      n_cmp++;
      if (nx != 0) begin
         n_bad++;
         $display("FAIL inv_xmit: got %0d strobes want 0", nx);
      end
   endtask

   task automatic test_full();
      logic [3:0] seq [9] = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h5};
      logic got = 1'b0;
      int nd = 0;
      int ne = 0;
      int nx = 0;
      logic [3:0] e;
      tx_mode = 1'b0;
      led_man = 1'b0;
      push = 1'b1;
      push_letter = 4'h2;
      exp_q.push_back(4'h2);
      tick();
      push = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (xmit) begin
            got = 1'b1;
            led_man = 1'b1;
            n_cmp++;
            e = exp_q.pop_front();
            if (letter !== e) begin
               n_bad++;
               $display("FAIL full_first_letter: got %0d want %0d", letter, e);
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL full_start: got no xmit within 8 cycles, want a strobe");
      end
      for (int i = 0; i < 9; i++) begin
         push = 1'b1;
         push_letter = seq[i];
         if (i < 8) exp_q.push_back(seq[i]);
         tick();
         if (xmit) nx++;
         if (i == 7) begin
            n_cmp++;
            if (count !== 4'(DEPTH) || full !== 1'b1 || err !== 1'b0) begin
               n_bad++;
               $display("FAIL full_flag: got count=%0d full=%0b err=%0b, want %0d 1 0", count, full, err, DEPTH);
            end
         end
         if (i == 8) begin
            n_cmp++;
            if (err !== 1'b1 || count !== 4'(DEPTH)) begin
               n_bad++;
               $display("FAIL full_overflow: got err=%0b count=%0d, want 1 %0d", err, count, DEPTH);
            end
         end
      end
      push = 1'b0;
      n_cmp++;
      if (nx != 0) begin
         n_bad++;
         $display("FAIL full_blocked: got %0d strobes while blocked, want 0", nx);
      end
      tx_mode = 1'b1;
      led_man = 1'b0;
      for (int i = 0; i < 400 && nd < 9; i++) begin
         tick();
         if (xmit) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL full_extra_xmit: got strobe letter=%0d, want none", letter);
            end else begin
               e = exp_q.pop_front();
               if (letter !== e) begin
                  n_bad++;
                  $display("FAIL full_drain_order: got %0d want %0d", letter, e);
               end
            end
         end
         if (done) nd++;
         if (err) ne++;
      end
      n_cmp++;
      if (nd != 9 || ne != 0) begin
         n_bad++;
         $display("FAIL full_drain: got done=%0d err=%0d, want 9 0", nd, ne);
      end
      n_cmp++;
      if (exp_q.size() != 0 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL full_drain_empty: got pending=%0d empty=%0b, want 0 1", exp_q.size(), empty);
      end
   endtask

   task automatic test_abort();
      int nx = 0;
      int bad_pulse = 0;
      logic [3:0] e;
      tx_mode = 1'b0;
      led_man = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push = 1'b1;
         push_letter = 4'(i + 1);
         exp_q.push_back(4'(i + 1));
         tick();
         if (xmit) begin
            nx++;
            n_cmp++;
            e = exp_q.pop_front();
            if (letter !== e) begin
               n_bad++;
               $display("FAIL abort_letter: got %0d want %0d", letter, e);
            end
         end
      end
      n_cmp++;
      if (nx != 1 || count !== 4'd5 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_setup: got strobes=%0d count=%0d busy=%0b, want 1 5 1", nx, count, busy);
      end
      abort = 1'b1;
      push = 1'b1;
      push_letter = 4'h7;
      tick();
      abort = 1'b0;
      push = 1'b0;
      exp_q.delete();
      n_cmp++;
      if ({count, empty, busy, xmit, done, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL abort_state: got count=%0d empty=%0b busy=%0b xmit=%0b done=%0b err=%0b, want 0 1 0 0 0 0",
                  count, empty, busy, xmit, done, err);
      end
      n_cmp++;
      if (letter !== 4'd1) begin
         n_bad++;
         $display("FAIL abort_letter_hold: got %0d want 1", letter);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (xmit || done || err || count != 4'd0) bad_pulse++;
      end
      n_cmp++;
      if (bad_pulse != 0) begin
         n_bad++;
         $display("FAIL abort_quiet: got %0d active cycles after abort, want 0", bad_pulse);
      end
   endtask

   task automatic test_reset_mid();
      logic got = 1'b0;
      int bad = 0;
      logic [3:0] e;
      tx_mode = 1'b0;
      led_man = 1'b0;
      push = 1'b1;
      push_letter = 4'h6;
      exp_q.push_back(4'h6);
      tick();
      push = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (xmit) begin
            got = 1'b1;
            led_man = 1'b1;
            n_cmp++;
            e = exp_q.pop_front();
            if (letter !== e) begin
               n_bad++;
               $display("FAIL rstmid_letter: got %0d want %0d", letter, e);
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rstmid_start: got no xmit within 8 cycles, want a strobe");
      end
      for (int i = 0; i < 3; i++) begin
         push = 1'b1;
         push_letter = 4'(i);
         tick();
      end
      push = 1'b0;
      led_man = 1'b0;
      tick();
      n_cmp++;
      if (count !== 4'd3 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_setup: got count=%0d busy=%0b, want 3 1", count, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({xmit, letter, count, empty, full, busy, done, err} !== {1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL rstmid_values: got xmit=%0b letter=%0d count=%0d empty=%0b full=%0b busy=%0b done=%0b err=%0b, want 0 0 0 1 0 0 0 0",
                  xmit, letter, count, empty, full, busy, done, err);
      end
      tick();
      tick();
      reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (xmit || !empty || busy) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL rstmid_after: got %0d cycles with activity after release, want 0", bad);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_timeout_invalid();
      test_full();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
